alu2_word_sequencer: RTL and testbench
======================================

ALU2_WORD_SEQUENCER -- requirements
Module: alu2_word_sequencer

Interface
REQ-001 SHALL have parameter NBYTES, default 4, number of 8-bit limbs per word (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for one ALU response (1..65535).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 aclk  in  1  clock; all state updates on rising edge.
REQ-005 areset  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  host command offered.
REQ-007 cmd_ready  out  1  sequencer accepts command this cycle.
REQ-008 cmd_opcode  in  3  ALU opcode applied to every limb.
REQ-009 cmd_carryin  in  1  carry into limb 0.
REQ-010 cmd_a, cmd_b  in  8*NBYTES  word operands.
REQ-011 rsp_valid  out  1  word result available.
REQ-012 rsp_ready  in  1  host consumes result.
REQ-013 rsp_result  out  8*NBYTES  assembled word result.
REQ-014 rsp_carry, rsp_zero, rsp_sign, rsp_error  out  1 each  word flags; error = ALU timeout.
REQ-015 alu_rx_enable, alu_rx_write, alu_rx_strobe, alu_rx_carryflag  out  1 each  ALU request controls.
REQ-016 alu_rx_opcode  out  3; alu_rx_operand0, alu_rx_operand1  out  8 each  ALU limb request.
REQ-017 alu_tx_result  in  8; alu_tx_carryflag, alu_tx_zeroflag, alu_tx_signflag, alu_tx_ready  in  1 each  ALU response.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: cmd_ready=1; on cmd_valid SHALL latch opcode, carryin, a, b; clear limb index and result; go ISSUE next cycle.
REQ-020 cmd_ready SHALL be 1 only in IDLE; commands are not accepted in any other state.
REQ-021 ISSUE: SHALL assert alu_rx_enable, alu_rx_write, alu_rx_strobe for exactly one cycle with operand0=a[8k+7:8k], operand1=b[8k+7:8k], opcode latched; go WAIT.
REQ-022 alu_rx_carryflag SHALL be cmd_carryin for limb 0 and the alu_tx_carryflag captured from limb k-1 for limb k>0.
REQ-023 alu_rx_enable SHALL stay high in ISSUE and WAIT, low in IDLE and RESP; alu_rx_write and alu_rx_strobe SHALL be low outside ISSUE.
REQ-024 WAIT: on alu_tx_ready SHALL store alu_tx_result in result[8k+7:8k] and capture carry; if k=NBYTES-1 go RESP, else increment k and go ISSUE.
REQ-025 alu_tx_ready seen in any state other than WAIT SHALL be ignored.
REQ-026 WAIT SHALL count cycles from 0; if count reaches TIMEOUT without alu_tx_ready, SHALL go RESP with rsp_error=1; unfinished limbs read 0.
REQ-027 Minimum latency, cmd accept to rsp_valid, with a 1-cycle ALU response: 2*NBYTES+1 cycles.
REQ-028 RESP: rsp_valid=1; rsp_carry = last captured carry; rsp_zero = (rsp_result==0); rsp_sign = rsp_result MSB.
REQ-029 rsp_* outputs SHALL stay stable while rsp_valid=1 and rsp_ready=0; on rsp_ready go IDLE next cycle.
REQ-030 A new command SHALL NOT be accepted in the same cycle the response is consumed; the earliest acceptance is the following cycle.

Reset
REQ-031 areset SHALL force IDLE on the next edge from any state, including mid-WAIT, and discard partial results.
REQ-032 After reset: cmd_ready=1, rsp_valid=0, all alu_rx_* =0, rsp_result=0, rsp_carry/zero/sign/error=0, limb index and timeout counter =0.
REQ-033 An alu_tx_ready arriving after reset SHALL be ignored.

Verification
REQ-034 With the bench ALU model implementing opcode 3'b000 as add-with-carry, 1-cycle response: a=0x0000_00FF, b=0x0000_0001, cin=0 -> rsp_result=0x0000_0100, carry=0, zero=0, sign=0, rsp_valid 9 cycles after accept.
REQ-035 Same setup: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_result=0x0000_0000, carry=1, zero=1, sign=0, error=0.
REQ-036 ALU never responds, TIMEOUT=4 -> rsp_valid with error=1 and result=0 after limb 0 has waited 4 cycles; the next command completes normally.
REQ-037 rsp_ready held low for 10 cycles -> outputs stable; cmd_valid held high is not accepted until the cycle after the rsp_ready handshake.
REQ-038 areset pulsed while waiting on limb 2 -> IDLE, all outputs at reset values; a late alu_tx_ready is ignored; the following command yields the correct result.

Source files
------------

// File: rtl/alu2_word_sequencer.sv
// Word-wide ALU sequencer: splits NBYTES-limb operands into 8-bit ALU requests,
// chains the carry limb to limb, and reassembles the word result and flags.
module alu2_word_sequencer #(
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_opcode,
  input  logic                cmd_carryin,
  input  logic [8*NBYTES-1:0] cmd_a,
  input  logic [8*NBYTES-1:0] cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_sign,
  output logic                rsp_error,
  output logic                alu_rx_enable,
  output logic                alu_rx_write,
  output logic                alu_rx_strobe,
  output logic                alu_rx_carryflag,
  output logic [2:0]          alu_rx_opcode,
  output logic [7:0]          alu_rx_operand0,
  output logic [7:0]          alu_rx_operand1,
  input  logic [7:0]          alu_tx_result,
  input  logic                alu_tx_carryflag,
  input  logic                alu_tx_zeroflag,
  input  logic                alu_tx_signflag,
  input  logic                alu_tx_ready
);
  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          cin_q, cin_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [7:0]    a_limb, b_limb;

  // Per-limb ALU flags are not needed: word flags derive from the assembled result.
  logic unused_flags;
  assign unused_flags = ^{alu_tx_zeroflag, alu_tx_signflag};

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == KW'(i)) begin
        a_limb = a_q[8*i +: 8];
        b_limb = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_opcode;
          cin_d   = cmd_carryin;
          a_d     = cmd_a;
          b_d     = cmd_b;
          res_d   = '0;
          k_d     = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_tx_ready) begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i)) res_d[8*i +: 8] = alu_tx_result;
          end
          carry_d = alu_tx_carryflag;
          if (k_q == KW'(NBYTES - 1)) begin
            state_d = RESP;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          // WAIT lasts exactly TIMEOUT cycles before giving up on this limb.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign alu_rx_enable    = (state_q == ISSUE) || (state_q == WAIT);
  assign alu_rx_write     = (state_q == ISSUE);
  assign alu_rx_strobe    = (state_q == ISSUE);
  assign alu_rx_opcode    = alu_rx_enable ? op_q   : '0;
  assign alu_rx_operand0  = alu_rx_enable ? a_limb : '0;
  assign alu_rx_operand1  = alu_rx_enable ? b_limb : '0;
  assign alu_rx_carryflag = alu_rx_enable & ((k_q == '0) ? cin_q : carry_q);

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_carry  = rsp_valid & carry_q;
  assign rsp_zero   = rsp_valid & (res_q == '0);
  assign rsp_sign   = rsp_valid & res_q[W-1];
  assign rsp_error  = rsp_valid & err_q;
endmodule

// File: tb/tb_alu2_word_sequencer.sv
// Directed bench for alu2_word_sequencer with a 1-cycle byte ALU model.
module tb_alu2_word_sequencer;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic        cmd_carryin = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_sign, rsp_error;
  logic        alu_rx_enable, alu_rx_write, alu_rx_strobe, alu_rx_carryflag;
  logic [2:0]  alu_rx_opcode;
  logic [7:0]  alu_rx_operand0, alu_rx_operand1;
  logic [7:0]  alu_tx_result = '0;
  logic        alu_tx_carryflag = 1'b0, alu_tx_zeroflag = 1'b0;
  logic        alu_tx_signflag = 1'b0, alu_tx_ready = 1'b0;

  int nvec = 0;
  int nmis = 0;
  int strobe_total = 0;
  int strobe_base = 0;
  int mute_at = 100;
  logic inject = 1'b0;

  alu2_word_sequencer #(.NBYTES(4), .TIMEOUT(4)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_carryin(cmd_carryin), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_error(rsp_error),
    .alu_rx_enable(alu_rx_enable), .alu_rx_write(alu_rx_write), .alu_rx_strobe(alu_rx_strobe),
    .alu_rx_carryflag(alu_rx_carryflag), .alu_rx_opcode(alu_rx_opcode),
    .alu_rx_operand0(alu_rx_operand0), .alu_rx_operand1(alu_rx_operand1),
    .alu_tx_result(alu_tx_result), .alu_tx_carryflag(alu_tx_carryflag),
    .alu_tx_zeroflag(alu_tx_zeroflag), .alu_tx_signflag(alu_tx_signflag),
    .alu_tx_ready(alu_tx_ready)
  );

  always #5 aclk = ~aclk;

  // Byte ALU: 000 add-with-carry, 001 and, 010 or, 011 xor; answers the cycle after a strobe.
  always @(posedge aclk) begin
    logic [8:0] s;
    alu_tx_ready <= inject;
    if (alu_rx_strobe && alu_rx_write && alu_rx_enable && (strobe_total - strobe_base) < mute_at) begin
      case (alu_rx_opcode)
        3'b000:  s = {1'b0, alu_rx_operand0} + {1'b0, alu_rx_operand1} + {8'd0, alu_rx_carryflag};
        3'b001:  s = {1'b0, alu_rx_operand0 & alu_rx_operand1};
        3'b010:  s = {1'b0, alu_rx_operand0 | alu_rx_operand1};
        3'b011:  s = {1'b0, alu_rx_operand0 ^ alu_rx_operand1};
        default: s = '0;
      endcase
      alu_tx_result    <= s[7:0];
      alu_tx_carryflag <= s[8];
      alu_tx_zeroflag  <= (s[7:0] == 8'd0);
      alu_tx_signflag  <= s[7];
      alu_tx_ready     <= 1'b1;
    end
    if (alu_rx_strobe) strobe_total <= strobe_total + 1;
  end

  typedef struct {
    logic [2:0]  op;
    logic        cin;
    logic [31:0] a, b, res;
    logic        c, z, s;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at the negedge of the accept cycle; returns at the negedge rsp_valid is first seen.
  task automatic wait_rsp(output int lat);
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge aclk);
      lat++;
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic cin, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    int n = 0;
    cmd_opcode = op; cmd_carryin = cin; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    strobe_base = strobe_total;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    wait_rsp(lat);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input int idx, input int lat);
    chk({tag, " latency"}, 64'(lat), 64'd9);
    chk({tag, " valid"},   64'(rsp_valid), 64'd1);
    chk({tag, " result"},  64'(rsp_result), 64'(vt[idx].res));
    chk({tag, " flags"},   64'({rsp_carry, rsp_zero, rsp_sign, rsp_error}),
        64'({vt[idx].c, vt[idx].z, vt[idx].s, 1'b0}));
  endtask

  task automatic run_vec(input int idx);
    int lat;
    do_cmd(vt[idx].op, vt[idx].cin, vt[idx].a, vt[idx].b, lat);
    check_rsp($sformatf("vec%0d", idx), idx, lat);
    chk($sformatf("vec%0d strobes", idx), 64'(strobe_total - strobe_base), 64'd4);
    consume();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ctl"},
        64'({cmd_ready, rsp_valid, alu_rx_enable, alu_rx_write, alu_rx_strobe, alu_rx_carryflag,
             alu_rx_opcode, alu_rx_operand0, alu_rx_operand1, rsp_carry, rsp_zero, rsp_sign, rsp_error}),
        64'({1'b1, 28'd0}));
    chk({tag, " result"}, 64'(rsp_result), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [36:0] snap;
    vt[0] = '{3'b000, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vt[1] = '{3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vt[2] = '{3'b000, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    vt[3] = '{3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vt[4] = '{3'b000, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vt[5] = '{3'b001, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1};
    vt[6] = '{3'b010, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vt[7] = '{3'b011, 1'b0, 32'hAAAA_5555, 32'h5555_AAAA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge aclk);
    areset = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 8; i++) run_vec(i);

    // ALU silent: limb 0 waits 4 cycles, then an error response with zero result.
    mute_at = 0;
    do_cmd(3'b000, 1'b0, 32'h0000_0001, 32'h0000_0002, lat);
    chk("timeout latency", 64'(lat), 64'd6);
    chk("timeout flags", 64'({rsp_valid, rsp_error, rsp_carry}), 64'b110);
    chk("timeout result", 64'(rsp_result), 64'd0);
    consume();
    mute_at = 100;
    run_vec(3);

    // Backpressure with a waiting command held on cmd_valid.
    do_cmd(vt[0].op, vt[0].cin, vt[0].a, vt[0].b, lat);
    check_rsp("stall", 0, lat);
    snap = {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_error};
    cmd_opcode = vt[1].op; cmd_carryin = vt[1].cin; cmd_a = vt[1].a; cmd_b = vt[1].b;
    cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk($sformatf("stall hold%0d", c),
          64'({cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_error}),
          64'({1'b0, snap}));
    end
    rsp_ready = 1'b1;
    chk("handshake no accept", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    rsp_ready = 1'b0;
    chk("accept after handshake", 64'({cmd_ready, rsp_valid}), 64'b10);
    strobe_base = strobe_total;
    wait_rsp(lat);
    check_rsp("held cmd", 1, lat);
    consume();

    // Reset while waiting on limb 2, then a stray late ALU response.
    mute_at = 2;
    cmd_opcode = vt[2].op; cmd_carryin = vt[2].cin; cmd_a = vt[2].a; cmd_b = vt[2].b;
    cmd_valid = 1'b1;
    strobe_base = strobe_total;
    @(negedge aclk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 50 && (strobe_total - strobe_base) < 3; c++) @(negedge aclk);
    chk("limb2 issued", 64'(strobe_total - strobe_base), 64'd3);
    repeat (2) @(negedge aclk);
    chk("mid wait", 64'({alu_rx_enable, alu_rx_strobe, rsp_valid, cmd_ready}), 64'b1000);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check_reset_state("midwait reset");
    inject = 1'b1;
    @(negedge aclk);
    inject = 1'b0;
    repeat (2) @(negedge aclk);
    check_reset_state("late ready");
    mute_at = 100;
    run_vec(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
